// File: rtl/snap_trig_ctrl.sv
// Capture sequencer for a snapshot BRAM: decodes the snap_trig control word into
// arm / trigger / abort / gating controls and writes exactly LENGTH samples.
module snap_trig_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LENGTH = 1024
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_word,
    input  logic              ext_trig,
    input  logic              din_valid,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       status,
    output logic              done_pulse
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // count is one bit wider than the address so it can report LENGTH = 2^ADDR_W
    localparam logic [ADDR_W:0] COUNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(LENGTH - 1);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [ADDR_W:0] count_r;
    logic [ADDR_W:0] count_nxt_s;
    logic            arm_q_r;
    logic            done_pulse_r;

    logic            arm_s;
    logic            trig_sel_s;
    logic            abort_s;
    logic            gate_en_s;
    logic            arm_edge_s;
    logic            bram_we_s;
    logic            last_write_s;
    logic            ctrl_unused_s;
    logic [31:0]     status_s;

    assign arm_s         = ctrl_word[0];
    assign trig_sel_s    = ctrl_word[1];
    assign abort_s       = ctrl_word[2];
    assign gate_en_s     = ctrl_word[3];
    assign ctrl_unused_s = ^ctrl_word[31:4];

    assign arm_edge_s    = arm_s & ~arm_q_r;

    // Write enable: only in CAPTURE, gated by din_valid if requested, killed by abort
    always_comb begin
        bram_we_s = 1'b0;
        if ((state_r == ST_CAPTURE) && !abort_s) begin
            if (gate_en_s) begin
                bram_we_s = din_valid;
            end else begin
                bram_we_s = 1'b1;
            end
        end else begin
            bram_we_s = 1'b0;
        end
    end

    assign last_write_s = bram_we_s && (count_r == LAST_COUNT);

    // Next-state and sample-count logic; abort overrides everything, including arm edges
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
            count_nxt_s = COUNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm_edge_s) begin
                        state_nxt_s = ST_ARMED;
                        count_nxt_s = COUNT_ZERO;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (!trig_sel_s || ext_trig) begin
                        state_nxt_s = ST_CAPTURE;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (bram_we_s) begin
                        count_nxt_s = count_r + COUNT_ONE;
                    end else begin
                        count_nxt_s = count_r;
                    end
                    if (last_write_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    if (arm_edge_s) begin
                        state_nxt_s = ST_ARMED;
                        count_nxt_s = COUNT_ZERO;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = COUNT_ZERO;
                end
            endcase
        end
    end

    // State, count, arm history and completion pulse registers
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_r      <= ST_IDLE;
            count_r      <= COUNT_ZERO;
            arm_q_r      <= 1'b0;
            done_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            arm_q_r      <= arm_s;
            done_pulse_r <= last_write_s;
        end
    end

    // Status word: state flags in the top bits, zero-extended sample count at the bottom
    always_comb begin
        status_s             = 32'd0;
        status_s[31]         = (state_r == ST_DONE);
        status_s[30]         = (state_r == ST_CAPTURE);
        status_s[29]         = (state_r == ST_ARMED);
        status_s[ADDR_W:0]   = count_r;
    end

    assign bram_we    = bram_we_s;
    assign bram_addr  = count_r[ADDR_W-1:0];
    assign status     = status_s;
    assign done_pulse = done_pulse_r;

endmodule

// File: tb/tb_snap_trig_ctrl.sv
// Directed bench for snap_trig_ctrl: a 16-sample full-range instance for most
// scenarios and an 8-sample instance for the gated-capture case.
module tb_snap_trig_ctrl;

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic [31:0] ctrl_a   = 32'd0;
    logic [31:0] ctrl_b   = 32'd0;
    logic        ext_trig = 1'b0;
    logic        din_a    = 1'b0;
    logic        din_b    = 1'b0;

    logic        we_a, dp_a, we_b, dp_b;
    logic [3:0]  addr_a;
    logic [2:0]  addr_b;
    logic [31:0] status_a, status_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 user_clk = ~user_clk;

    snap_trig_ctrl #(.ADDR_W(4), .LENGTH(16)) dut_a (
        .user_clk(user_clk), .user_rst(user_rst), .ctrl_word(ctrl_a),
        .ext_trig(ext_trig), .din_valid(din_a), .bram_we(we_a),
        .bram_addr(addr_a), .status(status_a), .done_pulse(dp_a)
    );

    snap_trig_ctrl #(.ADDR_W(3), .LENGTH(8)) dut_b (
        .user_clk(user_clk), .user_rst(user_rst), .ctrl_word(ctrl_b),
        .ext_trig(ext_trig), .din_valid(din_b), .bram_we(we_b),
        .bram_addr(addr_b), .status(status_b), .done_pulse(dp_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    // Arm dut_a in immediate mode and follow one complete 16-sample capture.
    task automatic imm_capture(input logic [31:0] pre_status);
        ctrl_a = 32'h0;
        step();
        ctrl_a = 32'h1;
        #1;
        check_eq("arm_cycle_status", status_a, pre_status);
        check_eq("arm_cycle_we", 32'(we_a), 32'd0);
        step();
        #1;
        check_eq("armed_t1", status_a, 32'h2000_0000);
        check_eq("armed_t1_we", 32'(we_a), 32'd0);
        step();
        for (int i = 0; i < 16; i++) begin
            #1;
            check_eq("imm_we", 32'(we_a), 32'd1);
            check_eq("imm_addr", 32'(addr_a), 32'(i));
            check_eq("imm_status", status_a, 32'h4000_0000 | 32'(i));
            step();
        end
        #1;
        check_eq("done_status", status_a, 32'h8000_0010);
        check_eq("done_pulse", 32'(dp_a), 32'd1);
        check_eq("done_we", 32'(we_a), 32'd0);
        step();
        #1;
        check_eq("done_pulse_single", 32'(dp_a), 32'd0);
        check_eq("done_status_hold", status_a, 32'h8000_0010);
    endtask

    initial begin
        // Reset
        repeat (3) step();
        #1;
        check_eq("rst_status", status_a, 32'd0);
        check_eq("rst_we", 32'(we_a), 32'd0);
        check_eq("rst_addr", 32'(addr_a), 32'd0);
        check_eq("rst_dp", 32'(dp_a), 32'd0);
        user_rst = 1'b0;
        step();

        // Abort together with an arm edge: the edge is consumed
        ctrl_a = 32'h5;
        #1;
        check_eq("abort_edge_we", 32'(we_a), 32'd0);
        step();
        ctrl_a = 32'h1;
        #1;
        check_eq("abort_beats_arm", status_a, 32'd0);
        step();
        #1;
        check_eq("edge_consumed", status_a, 32'd0);

        // Immediate capture, DONE holding, then re-arm from DONE
        imm_capture(32'd0);
        repeat (5) step();
        #1;
        check_eq("done_holds", status_a, 32'h8000_0010);
        imm_capture(32'h8000_0010);

        // External trigger: 50 idle cycles armed, then a one-cycle trigger
        ctrl_a = 32'h0;
        step();
        ctrl_a = 32'h3;
        #1;
        check_eq("ext_arm_cycle", status_a, 32'h8000_0010);
        step();
        for (int i = 0; i < 50; i++) begin
            #1;
            check_eq("ext_wait_we", 32'(we_a), 32'd0);
            check_eq("ext_wait_status", status_a, 32'h2000_0000);
            step();
        end
        ext_trig = 1'b1;
        #1;
        check_eq("trig_cycle_we", 32'(we_a), 32'd0);
        step();
        ext_trig = 1'b0;

        // Writes 0..4; a fresh arm edge at i==2 must not disturb the count
        for (int i = 0; i < 5; i++) begin
            if (i == 1) ctrl_a = 32'h2;
            else if (i == 2) ctrl_a = 32'h3;
            #1;
            check_eq("ext_we", 32'(we_a), 32'd1);
            check_eq("ext_addr", 32'(addr_a), 32'(i));
            check_eq("ext_status", status_a, 32'h4000_0000 | 32'(i));
            step();
        end

        // Abort at count 5, then a fresh capture from address 0
        ctrl_a = 32'h5;
        #1;
        check_eq("abort_we", 32'(we_a), 32'd0);
        check_eq("abort_cycle_status", status_a, 32'h4000_0005);
        step();
        #1;
        check_eq("abort_idle_status", status_a, 32'd0);
        check_eq("abort_idle_we", 32'(we_a), 32'd0);
        ctrl_a = 32'h0;
        step();
        imm_capture(32'd0);

        // Reset held for three cycles in the middle of a capture
        ctrl_a = 32'h0;
        step();
        ctrl_a = 32'h1;
        step();
        step();
        step();
        step();
        #1;
        check_eq("pre_rst_we", 32'(we_a), 32'd1);
        check_eq("pre_rst_addr", 32'(addr_a), 32'd2);
        user_rst = 1'b1;
        ctrl_a   = 32'h0;
        step();
        #1;
        check_eq("mid_rst_status", status_a, 32'd0);
        check_eq("mid_rst_we", 32'(we_a), 32'd0);
        check_eq("mid_rst_addr", 32'(addr_a), 32'd0);
        check_eq("mid_rst_dp", 32'(dp_a), 32'd0);
        step();
        step();
        user_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check_eq("post_rst_status", status_a, 32'd0);
            check_eq("post_rst_we", 32'(we_a), 32'd0);
        end

        // Gated capture on the 8-sample instance, din_valid alternating
        ctrl_b = 32'h9;
        din_b  = 1'b0;
        #1;
        check_eq("gate_arm_cycle", status_b, 32'd0);
        step();
        #1;
        check_eq("gate_armed", status_b, 32'h2000_0000);
        step();
        for (int k = 0; k < 15; k++) begin
            din_b = (k % 2 == 0);
            #1;
            check_eq("gate_we", 32'(we_b), 32'(din_b));
            check_eq("gate_addr", 32'(addr_b), 32'((k + 1) / 2));
            check_eq("gate_status", status_b, 32'h4000_0000 | 32'((k + 1) / 2));
            step();
        end
        din_b = 1'b0;
        #1;
        check_eq("gate_done_status", status_b, 32'h8000_0008);
        check_eq("gate_done_pulse", 32'(dp_b), 32'd1);
        check_eq("gate_done_we", 32'(we_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
